ro_puf_eval_ctrl: RTL and testbench

//  Measurement sequencer and response generator sitting directly downstream of (and driving) the pair of RO edge counters.
//  For each response bit it selects an RO pair, clears both counters, opens a fixed counting window, lets the counts settle,

---
 rtl/ro_puf_eval_ctrl_if.sv | 29 ++
 rtl/ro_puf_eval_ctrl.sv | 150 +++++++++++++++
 tb/tb_ro_puf_eval_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_puf_eval_ctrl_if.sv
// Bundle between the RO-PUF evaluation controller and its environment:
// challenge/response handshake plus the RO counter control and count inputs.
interface ro_puf_eval_ctrl_if #(
   parameter int CNT_W  = 16,
   parameter int N_BITS = 8,
   parameter int PAIR_W = 4
);
   logic                       start;
   logic [N_BITS*PAIR_W-1:0]   challenge;
   logic [PAIR_W-1:0]          pair_sel;
   logic                       cnt_reset;
   logic                       cnt_enable;
   logic [CNT_W-1:0]           count_a;
   logic [CNT_W-1:0]           count_b;
   logic                       busy;
   logic                       done;
   logic [N_BITS-1:0]          response;
   logic [N_BITS-1:0]          tie_mask;

   modport master (
      output start, challenge, count_a, count_b,
      input  pair_sel, cnt_reset, cnt_enable, busy, done, response, tie_mask
   );

   modport slave (
      input  start, challenge, count_a, count_b,
      output pair_sel, cnt_reset, cnt_enable, busy, done, response, tie_mask
   );
endinterface

// File: rtl/ro_puf_eval_ctrl.sv
// RO-PUF measurement sequencer: per response bit it selects an RO pair, clears and
// runs both edge counters for a fixed window, lets them settle, then compares counts.
module ro_puf_eval_ctrl #(
   parameter int CNT_W         = 16,
   parameter int N_BITS        = 8,
   parameter int PAIR_W        = 4,
   parameter int WINDOW_CYCLES = 1024,
   parameter int SETTLE_CYCLES = 4
) (
   input logic                clk,
   input logic                reset,
   ro_puf_eval_ctrl_if.slave  bus
);
   localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_COUNT, S_SETTLE, S_COMPARE, S_DONE
   } state_t;

   state_t                     state_reg, state_next;
   logic [TMR_W-1:0]           tmr_reg, tmr_next;
   logic [IDX_W-1:0]           idx_reg, idx_next;
   logic [N_BITS*PAIR_W-1:0]   chal_reg, chal_next;
   logic [PAIR_W-1:0]          pair_sel_reg, pair_sel_next;
   logic                       cnt_reset_reg, cnt_reset_next;
   logic                       cnt_enable_reg, cnt_enable_next;
   logic                       busy_reg, busy_next;
   logic                       done_reg, done_next;
   logic [N_BITS-1:0]          response_reg, response_next;
   logic [N_BITS-1:0]          tie_mask_reg, tie_mask_next;
   logic [PAIR_W-1:0]          slice [N_BITS];

   // Slices of the challenge that will be in effect after this edge, so the
   // very first CLEAR already drives the freshly latched pair select.
   generate
      for (genvar gi = 0; gi < N_BITS; gi++) begin : g_slice
         assign slice[gi] = chal_next[gi*PAIR_W +: PAIR_W];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         tmr_reg        <= '0;
         idx_reg        <= '0;
         chal_reg       <= '0;
         pair_sel_reg   <= '0;
         cnt_reset_reg  <= 1'b1;
         cnt_enable_reg <= 1'b0;
         busy_reg       <= 1'b0;
         done_reg       <= 1'b0;
         response_reg   <= '0;
         tie_mask_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         tmr_reg        <= tmr_next;
         idx_reg        <= idx_next;
         chal_reg       <= chal_next;
         pair_sel_reg   <= pair_sel_next;
         cnt_reset_reg  <= cnt_reset_next;
         cnt_enable_reg <= cnt_enable_next;
         busy_reg       <= busy_next;
         done_reg       <= done_next;
         response_reg   <= response_next;
         tie_mask_reg   <= tie_mask_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      tmr_next      = tmr_reg;
      idx_next      = idx_reg;
      chal_next     = chal_reg;
      response_next = response_reg;
      tie_mask_next = tie_mask_reg;

      // tmr_reg holds the remaining cycles minus one for the current timed state
      case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               chal_next     = bus.challenge;
               idx_next      = '0;
               response_next = '0;
               tie_mask_next = '0;
               tmr_next      = TMR_W'(1);
               state_next    = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (tmr_reg == '0) begin
               tmr_next   = TMR_W'(WINDOW_CYCLES - 1);
               state_next = S_COUNT;
            end else begin
               tmr_next = tmr_reg - TMR_W'(1);
            end
         end
         S_COUNT: begin
            if (tmr_reg == '0) begin
               tmr_next   = TMR_W'(SETTLE_CYCLES - 1);
               state_next = S_SETTLE;
            end else begin
               tmr_next = tmr_reg - TMR_W'(1);
            end
         end
         S_SETTLE: begin
            if (tmr_reg == '0) begin
               state_next = S_COMPARE;
            end else begin
               tmr_next = tmr_reg - TMR_W'(1);
            end
         end
         S_COMPARE: begin
            response_next[idx_reg] = (bus.count_a > bus.count_b);
            tie_mask_next[idx_reg] = (bus.count_a == bus.count_b);
            if (idx_reg == IDX_W'(N_BITS - 1)) begin
               state_next = S_DONE;
            end else begin
               idx_next   = idx_reg + IDX_W'(1);
               tmr_next   = TMR_W'(1);
               state_next = S_CLEAR;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the state being entered, so they line up with it.
   always_comb begin
      cnt_enable_next = (state_next == S_COUNT);
      cnt_reset_next  = (state_next == S_IDLE) || (state_next == S_CLEAR) || (state_next == S_DONE);
      busy_next       = (state_next == S_CLEAR) || (state_next == S_COUNT) ||
                        (state_next == S_SETTLE) || (state_next == S_COMPARE);
      done_next       = (state_next == S_DONE);
      pair_sel_next   = pair_sel_reg;
      if (state_next == S_CLEAR) begin
         pair_sel_next = slice[idx_next];
      end
   end

   assign bus.pair_sel   = pair_sel_reg;
   assign bus.cnt_reset  = cnt_reset_reg;
   assign bus.cnt_enable = cnt_enable_reg;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
   assign bus.response   = response_reg;
   assign bus.tie_mask   = tie_mask_reg;
endmodule

// File: tb/tb_ro_puf_eval_ctrl.sv
// Randomised bench for ro_puf_eval_ctrl: RO counter models with per-pair rates and a
// cycle-timeline reference model checked every cycle, plus literal spot checks.
module tb_ro_puf_eval_ctrl;
   localparam int CNT_W = 16;
   localparam int N     = 4;
   localparam int PW    = 4;
   localparam int W     = 16;
   localparam int S     = 2;
   localparam int P     = 3 + W + S;
   localparam int M     = N * P;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ro_puf_eval_ctrl_if #(.CNT_W(CNT_W), .N_BITS(N), .PAIR_W(PW)) bus ();

   ro_puf_eval_ctrl #(
      .CNT_W(CNT_W), .N_BITS(N), .PAIR_W(PW),
      .WINDOW_CYCLES(W), .SETTLE_CYCLES(S)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   bit armed = 1'b0;
   int rate_a [16];
   int rate_b [16];

   // RO edge counters: each pair counts at a fixed rate per enabled cycle
   logic [CNT_W-1:0] ca = '0;
   logic [CNT_W-1:0] cb = '0;
   always @(posedge clk) begin
      if (bus.cnt_reset === 1'b1) begin
         ca <= '0;
         cb <= '0;
      end else if (bus.cnt_enable === 1'b1) begin
         ca <= ca + CNT_W'(rate_a[bus.pair_sel]);
         cb <= cb + CNT_W'(rate_b[bus.pair_sel]);
      end
   end
   assign bus.count_a = ca;
   assign bus.count_b = cb;

   int en_cycles = 0;
   always @(posedge clk) if (bus.cnt_enable === 1'b1) en_cycles <= en_cycles + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] predict(input logic [15:0] chal);
      logic [3:0] r, tm;
      int sel, a, b;
      r  = '0;
      tm = '0;
      for (int i = 0; i < N; i++) begin
         sel   = int'((chal >> (i * PW)) & 16'hF);
         a     = rate_a[sel] * W;
         b     = rate_b[sel] * W;
         r[i]  = (a > b);
         tm[i] = (a == b);
      end
      return {tm, r};
   endfunction

   // Reference: t counts cycles since the accepting edge, -1 when idle
   int          t    = -1;
   logic [7:0]  fin  = '0;
   logic [7:0]  held = '0;
   logic [15:0] snap = '0;
   always @(posedge clk) begin
      if (reset) begin
         t    <= -1;
         held <= '0;
      end else if (t < 0) begin
         if (bus.start === 1'b1) begin
            t    <= 0;
            snap <= bus.challenge;
            fin  <= predict(bus.challenge);
         end
      end else if (t == M) begin
         t    <= -1;
         held <= fin;
      end else begin
         t <= t + 1;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         if (t < 0) begin
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_done", 32'(bus.done), 32'd0);
            chk("idle_en", 32'(bus.cnt_enable), 32'd0);
            chk("idle_crst", 32'(bus.cnt_reset), 32'd1);
            chk("idle_resp", 32'(bus.response), 32'(held[3:0]));
            chk("idle_tie", 32'(bus.tie_mask), 32'(held[7:4]));
         end else if (t == M) begin
            chk("done_busy", 32'(bus.busy), 32'd0);
            chk("done_done", 32'(bus.done), 32'd1);
            chk("done_en", 32'(bus.cnt_enable), 32'd0);
            chk("done_resp", 32'(bus.response), 32'(fin[3:0]));
            chk("done_tie", 32'(bus.tie_mask), 32'(fin[7:4]));
         end else begin
            int ph, b;
            logic [3:0] mask;
            ph   = t % P;
            b    = t / P;
            mask = 4'((1 << b) - 1);
            chk("run_busy", 32'(bus.busy), 32'd1);
            chk("run_done", 32'(bus.done), 32'd0);
            chk("run_en", 32'(bus.cnt_enable), 32'((ph >= 2) && (ph < 2 + W)));
            chk("run_crst", 32'(bus.cnt_reset), 32'(ph < 2));
            chk("run_sel", 32'(bus.pair_sel), 32'((snap >> (b * PW)) & 16'hF));
            chk("run_resp", 32'(bus.response), 32'(fin[3:0] & mask));
            chk("run_tie", 32'(bus.tie_mask), 32'(fin[7:4] & mask));
         end
      end
   end

   // Called at a negedge; returns the cycle index of the done pulse, counting the start cycle as 0
   task automatic run(input logic [15:0] chal, input bit noisy, output int cycles);
      bus.challenge = chal;
      bus.start     = 1'b1;
      cycles        = 0;
      @(posedge clk);
      cycles = 1;
      @(negedge clk);
      bus.start = 1'b0;
      while (bus.done !== 1'b1 && cycles < 500) begin
         @(posedge clk);
         cycles++;
         @(negedge clk);
         if (noisy) begin
            bus.start     = 1'($urandom_range(1));
            bus.challenge = 16'($urandom);
         end
      end
      bus.start = 1'b0;
      if (bus.done !== 1'b1) chk("done_timeout", 32'(cycles), 32'(M + 1));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int cyc, en0, dones;
      bus.start     = 1'b0;
      bus.challenge = '0;
      for (int i = 0; i < 16; i++) begin
         rate_a[i] = 1;
         rate_b[i] = 1;
      end
      rate_a[0] = 3; rate_b[0] = 1;
      rate_a[1] = 1; rate_b[1] = 2;
      rate_a[2] = 2; rate_b[2] = 1;
      rate_a[3] = 1; rate_b[3] = 3;

      // 1: reset then idle
      idle(2);
      armed = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(5);
      chk("t1_crst", 32'(bus.cnt_reset), 32'd1);
      chk("t1_en", 32'(bus.cnt_enable), 32'd0);
      chk("t1_busy", 32'(bus.busy), 32'd0);
      chk("t1_done", 32'(bus.done), 32'd0);
      chk("t1_resp", 32'(bus.response), 32'd0);

      // 2: nominal evaluation
      en0 = en_cycles;
      run(16'h3210, 1'b0, cyc);
      chk("t2_latency", 32'(cyc), 32'd85);
      chk("t2_resp", 32'(bus.response), 32'b0101);
      chk("t2_tie", 32'(bus.tie_mask), 32'd0);
      chk("t2_en_cycles", 32'(en_cycles - en0), 32'd64);
      idle(3);

      // 3: forced tie on pair 1
      rate_a[1] = 2; rate_b[1] = 2;
      run(16'h3210, 1'b0, cyc);
      chk("t3_resp", 32'(bus.response), 32'b0101);
      chk("t3_tie", 32'(bus.tie_mask), 32'b0010);
      rate_a[1] = 1; rate_b[1] = 2;
      idle(2);

      // 4: reset during COUNT of bit 2
      bus.challenge = 16'h3210;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      idle(2 * P + 6);
      chk("t4_pre_en", 32'(bus.cnt_enable), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t4_en", 32'(bus.cnt_enable), 32'd0);
      chk("t4_crst", 32'(bus.cnt_reset), 32'd1);
      chk("t4_busy", 32'(bus.busy), 32'd0);
      chk("t4_resp", 32'(bus.response), 32'd0);
      dones = 0;
      repeat (M) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      chk("t4_no_done", 32'(dones), 32'd0);

      // 5: start pulsed and challenge toggled while busy
      run(16'h3210, 1'b1, cyc);
      chk("t5_latency", 32'(cyc), 32'd85);
      chk("t5_resp", 32'(bus.response), 32'b0101);
      @(negedge clk);
      chk("t5_single_done", 32'(bus.done), 32'd0);

      // 6: back-to-back, prior response held until the new start
      chk("t6_held", 32'(bus.response), 32'b0101);
      run(16'h0123, 1'b0, cyc);
      chk("t6_resp", 32'(bus.response), 32'b1010);
      chk("t6_latency", 32'(cyc), 32'd85);

      // random runs with random pair rates (ties likely)
      for (int r = 0; r < 8; r++) begin
         idle(1 + $urandom_range(4));
         for (int i = 0; i < 16; i++) begin
            rate_a[i] = 1 + $urandom_range(2);
            rate_b[i] = 1 + $urandom_range(2);
         end
         run(16'($urandom), ($urandom_range(1) == 1), cyc);
         chk("rnd_latency", 32'(cyc), 32'(M + 1));
      end
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
